sec_ded_scrub_ctrl: RTL

ECC scrubber for a SEC-DED protected memory bank in MemSys. It walks addresses 0..cfg_last_addr, reads each word plus check bits, and runs them through the SEC-DED decoder. Single-bit errors are written back corrected; double-bit errors are counted and logged. It shares the bank with functional traffic through a req/gnt port and is throttled by a programmable gap.

---
 rtl/memsys_ecc_pkg.sv | 42 ++++
 rtl/sec_ded_hasio_decode.sv | 44 ++++
 rtl/sec_ded_scrub_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/memsys_ecc_pkg.sv
// rtl/memsys_ecc_pkg.sv - shared types and SEC-DED helpers for the memsys ECC scrubber
package memsys_ecc_pkg;

    localparam int DEF_CNTW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_EVAL,
        ST_WR_REQ,
        ST_NEXT
    } scrub_state_e;

    // Check-bit width paired with a data width: Hamming bound plus one parity bit.
    function automatic int ecc_cw(input int dw);
        int r;
        r = 1;
        while ((1 << r) < dw + r + 1) r++;
        return r + 1;
    endfunction

    // Column idx of the Hsiao H matrix: the idx-th odd-weight (>=3) value in ascending order.
    function automatic logic [31:0] hsiao_col(input int cw, input int idx);
        int n;
        int w;
        logic [31:0] res;
        n   = 0;
        res = '0;
        for (int v = 1; v < (1 << cw); v++) begin
            w = 0;
            for (int b = 0; b < 32; b++) w += (v >> b) & 1;
            if (w >= 3 && (w % 2) == 1) begin
                if (n == idx) res = v;
                n++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sec_ded_hasio_decode.sv
// rtl/sec_ded_hasio_decode.sv - combinational Hsiao SEC-DED decoder and check-bit regenerator
module sec_ded_hasio_decode
    import memsys_ecc_pkg::*;
#(
    parameter int DW = 11,
    parameter int CW = ecc_cw(DW)
) (
    input  logic [DW-1:0] data,
    input  logic [CW-1:0] chk,
    output logic          sec,
    output logic          ded,
    output logic [DW-1:0] data_corr,
    output logic [CW-1:0] control_new
);

    logic [CW-1:0] h_col [DW];
    logic [CW-1:0] calc;
    logic [CW-1:0] syn;

    for (genvar i = 0; i < DW; i++) begin : g_col
        localparam logic [31:0] COL = hsiao_col(CW, i);
        assign h_col[i] = COL[CW-1:0];
    end

    // Odd-weight syndromes are all single-bit positions; even non-zero ones are double errors.
    always_comb begin
        calc = '0;
        for (int i = 0; i < DW; i++) begin
            if (data[i]) calc = calc ^ h_col[i];
        end
        syn = calc ^ chk;
        sec = (syn != '0) && (^syn);
        ded = (syn != '0) && !(^syn);
        data_corr = data;
        for (int i = 0; i < DW; i++) begin
            if (sec && syn == h_col[i]) data_corr[i] = ~data[i];
        end
        control_new = '0;
        for (int i = 0; i < DW; i++) begin
            if (data_corr[i]) control_new = control_new ^ h_col[i];
        end
    end

endmodule

// File: rtl/sec_ded_scrub_ctrl.sv
// rtl/sec_ded_scrub_ctrl.sv - background SEC-DED scrubber walking one memory bank
module sec_ded_scrub_ctrl
    import memsys_ecc_pkg::*;
#(
    parameter int DW   = 11,
    parameter int CW   = 5,
    parameter int AW   = 8,
    parameter int CNTW = DEF_CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic            cont,
    input  logic            clr_stats,
    input  logic [AW-1:0]   cfg_last_addr,
    input  logic [15:0]     cfg_gap,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [CW-1:0]   mem_wchk,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,
    input  logic [CW-1:0]   mem_rchk,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] sec_cnt,
    output logic [CNTW-1:0] ded_cnt,
    output logic            ded_flag,
    output logic [AW-1:0]   ded_addr
);

    scrub_state_e  state;
    logic [AW-1:0] addr;
    logic [15:0]   gap_cnt;
    logic          stop_pend;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] rd_chk;

    logic          dec_sec;
    logic          dec_ded;
    logic [DW-1:0] dec_data;
    logic [CW-1:0] dec_chk;

    sec_ded_hasio_decode #(.DW(DW)) u_decode (
        .data        (rd_data),
        .chk         (rd_chk),
        .sec         (dec_sec),
        .ded         (dec_ded),
        .data_corr   (dec_data),
        .control_new (dec_chk)
    );

    assign mem_addr = addr;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            addr      <= '0;
            gap_cnt   <= '0;
            stop_pend <= 1'b0;
            rd_data   <= '0;
            rd_chk    <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_wchk  <= '0;
            done      <= 1'b0;
            sec_cnt   <= '0;
            ded_cnt   <= '0;
            ded_flag  <= 1'b0;
            ded_addr  <= '0;
        end else begin
            done <= 1'b0;
            if (stop && state != ST_IDLE) stop_pend <= 1'b1;

            case (state)
                ST_IDLE: begin
                    stop_pend <= 1'b0;
                    if (start) begin
                        addr    <= '0;
                        gap_cnt <= cfg_gap;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Nothing is in flight during the gap, so stop takes effect at once.
                    if (stop) begin
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (gap_cnt == '0) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                        state   <= ST_RD_REQ;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        rd_data <= mem_rdata;
                        rd_chk  <= mem_rchk;
                        state   <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (dec_ded) begin
                        if (ded_cnt != '1) ded_cnt <= ded_cnt + CNTW'(1);
                        if (!ded_flag) begin
                            ded_flag <= 1'b1;
                            ded_addr <= addr;
                        end
                        state <= ST_NEXT;
                    end else if (dec_sec) begin
                        if (sec_cnt != '1) sec_cnt <= sec_cnt + CNTW'(1);
                        mem_wdata <= dec_data;
                        mem_wchk  <= dec_chk;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        state     <= ST_WR_REQ;
                    end else begin
                        state <= ST_NEXT;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (stop_pend || stop) begin
                        stop_pend <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (addr == cfg_last_addr) begin
                        done <= 1'b1;
                        if (cont) begin
                            addr    <= '0;
                            gap_cnt <= cfg_gap;
                            state   <= ST_GAP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        addr    <= addr + AW'(1);
                        gap_cnt <= cfg_gap;
                        state   <= ST_GAP;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed last so a clear beats an increment in the same cycle.
            if (clr_stats) begin
                sec_cnt  <= '0;
                ded_cnt  <= '0;
                ded_flag <= 1'b0;
                ded_addr <= '0;
            end
        end
    end

endmodule
